// File: rtl/mem_bus_ctrl.sv
// Single-word load/store sequencer for an SRAM-style bus: IDLE -> SETUP -> ACCESS -> HOLD.
// Optional bus watchdog (BusErr, RData=FFFF on expiry) is compiled in with `define MEM_TIMEOUT_EN.
module mem_bus_ctrl #(
    parameter int unsigned WAIT_STATES    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        Clock,
    input  logic        nReset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [15:0] Addr,
    input  logic [15:0] WData,
    output logic [15:0] RData,
    output logic        Busy,
    output logic        Done,
    output logic        BusErr,
    output logic [15:0] SysAddr,
    output logic [15:0] SysDataOut,
    output logic        SysDataOe,
    input  logic [15:0] SysDataIn,
    output logic        nSysCe,
    output logic        nSysOe,
    output logic        nSysWe,
    input  logic        SysRdy
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    if (WAIT_STATES > 15) begin : g_bad_wait
        $error("WAIT_STATES must be in 0..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_t     state_reg;
    logic       write_reg;
    logic [3:0] wait_cnt_reg;
    logic       ready_hit;

    // SysRdy only counts once the minimum strobe time has elapsed
    assign ready_hit = (wait_cnt_reg == 4'd0) && SysRdy;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wd_cnt_reg;
    logic       timeout;
    assign timeout = (wd_cnt_reg == 8'(TIMEOUT_CYCLES - 1));
`else
    assign BusErr = 1'b0;
`endif

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_reg    <= IDLE;
            write_reg    <= 1'b0;
            wait_cnt_reg <= 4'd0;
            RData        <= 16'h0000;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            SysAddr      <= 16'h0000;
            SysDataOut   <= 16'h0000;
            SysDataOe    <= 1'b0;
            nSysCe       <= 1'b1;
            nSysOe       <= 1'b1;
            nSysWe       <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            wd_cnt_reg   <= 8'd0;
            BusErr       <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            BusErr <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (MemReq) begin
                        // Outputs registered here are the SETUP-cycle bus values
                        state_reg    <= SETUP;
                        Busy         <= 1'b1;
                        write_reg    <= MemWrite;
                        wait_cnt_reg <= 4'(WAIT_STATES);
                        SysAddr      <= Addr;
                        nSysCe       <= 1'b0;
                        if (MemWrite) begin
                            SysDataOut <= WData;
                            SysDataOe  <= 1'b1;
                        end
`ifdef MEM_TIMEOUT_EN
                        wd_cnt_reg <= 8'd0;
`endif
                    end
                end
                SETUP: begin
                    state_reg <= ACCESS;
                    if (write_reg) nSysWe <= 1'b0;
                    else           nSysOe <= 1'b0;
                end
                ACCESS: begin
                    if (wait_cnt_reg != 4'd0) wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    if (ready_hit) begin
                        state_reg <= HOLD;
                        nSysOe    <= 1'b1;
                        nSysWe    <= 1'b1;
                        Done      <= 1'b1;
                        if (!write_reg) RData <= SysDataIn;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (timeout) begin
                        state_reg <= HOLD;
                        nSysOe    <= 1'b1;
                        nSysWe    <= 1'b1;
                        Done      <= 1'b1;
                        BusErr    <= 1'b1;
                        if (!write_reg) RData <= 16'hFFFF;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 8'd1;
                    end
`endif
                end
                HOLD: begin
                    state_reg <= IDLE;
                    Busy      <= 1'b0;
                    nSysCe    <= 1'b1;
                    SysDataOe <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: one instance with WAIT_STATES=0, one with WAIT_STATES=2.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        mem_req, mem_req2, mem_write;
    logic [15:0] addr, wdata, sys_data_in;
    logic        sys_rdy;

    logic [15:0] r_data, sys_addr, sys_data_out;
    logic        busy, done, bus_err, sys_data_oe, n_sys_ce, n_sys_oe, n_sys_we;
    logic [15:0] r_data2, sys_addr2, sys_data_out2;
    logic        busy2, done2, bus_err2, sys_data_oe2, n_sys_ce2, n_sys_oe2, n_sys_we2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.WAIT_STATES(0), .TIMEOUT_CYCLES(8)) dut (
        .Clock(clk), .nReset(n_reset), .MemReq(mem_req), .MemWrite(mem_write),
        .Addr(addr), .WData(wdata), .RData(r_data), .Busy(busy), .Done(done),
        .BusErr(bus_err), .SysAddr(sys_addr), .SysDataOut(sys_data_out),
        .SysDataOe(sys_data_oe), .SysDataIn(sys_data_in), .nSysCe(n_sys_ce),
        .nSysOe(n_sys_oe), .nSysWe(n_sys_we), .SysRdy(sys_rdy)
    );

    mem_bus_ctrl #(.WAIT_STATES(2), .TIMEOUT_CYCLES(8)) dut2 (
        .Clock(clk), .nReset(n_reset), .MemReq(mem_req2), .MemWrite(mem_write),
        .Addr(addr), .WData(wdata), .RData(r_data2), .Busy(busy2), .Done(done2),
        .BusErr(bus_err2), .SysAddr(sys_addr2), .SysDataOut(sys_data_out2),
        .SysDataOe(sys_data_oe2), .SysDataIn(sys_data_in), .nSysCe(n_sys_ce2),
        .nSysOe(n_sys_oe2), .nSysWe(n_sys_we2), .SysRdy(sys_rdy)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int we_low, oe_low, oe_drv, addr_bad, done_cnt, done_at, done_at2, overlap, err_at;
        logic [15:0] rdata_early;

        n_reset = 1'b0; mem_req = 1'b0; mem_req2 = 1'b0; mem_write = 1'b0;
        addr = 16'h0; wdata = 16'h0; sys_data_in = 16'h0; sys_rdy = 1'b1;
        tick; tick;
        check("rst_rdata", r_data, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_buserr", bus_err, 1'b0);
        check("rst_sysaddr", sys_addr, 16'h0);
        check("rst_oe_drv", sys_data_oe, 1'b0);
        check("rst_strobes", {n_sys_ce, n_sys_oe, n_sys_we}, 3'b111);
        n_reset = 1'b1;
        tick;

        // Load, zero wait states
        addr = 16'h0040; mem_write = 1'b0; sys_data_in = 16'hBEEF; mem_req = 1'b1;
        tick; mem_req = 1'b0;
        check("t1_setup_busy", busy, 1'b1);
        check("t1_setup_ce", n_sys_ce, 1'b0);
        check("t1_setup_oe", n_sys_oe, 1'b1);
        check("t1_setup_addr", sys_addr, 16'h0040);
        tick;
        check("t1_access_oe", n_sys_oe, 1'b0);
        check("t1_access_done", done, 1'b0);
        tick;
        check("t1_hold_done", done, 1'b1);
        check("t1_hold_oe", n_sys_oe, 1'b1);
        check("t1_hold_ce", n_sys_ce, 1'b0);
        check("t1_rdata", r_data, 16'hBEEF);
        tick;
        check("t1_idle_done", done, 1'b0);
        check("t1_idle_busy", busy, 1'b0);
        check("t1_idle_ce", n_sys_ce, 1'b1);
        $display("txn1 load addr=0040 rdata=%h", r_data);

        // Store, two wait states (second instance)
        addr = 16'h1234; wdata = 16'hA5A5; mem_write = 1'b1; mem_req2 = 1'b1;
        tick; mem_req2 = 1'b0; addr = 16'hFFFF; wdata = 16'h0000; mem_write = 1'b0;
        we_low = 0; oe_low = 0; oe_drv = 0; addr_bad = 0; done_cnt = 0; done_at = 0;
        for (int i = 1; i <= 6; i++) begin
            if (!n_sys_we2) we_low++;
            if (!n_sys_oe2) oe_low++;
            if (sys_data_oe2) oe_drv++;
            if (i <= 5 && (sys_addr2 != 16'h1234 || sys_data_out2 != 16'hA5A5)) addr_bad++;
            if (done2) begin done_cnt++; done_at = i; end
            tick;
        end
        check("t2_we_low_cycles", 16'(we_low), 16'd3);
        check("t2_oe_low_cycles", 16'(oe_low), 16'd0);
        check("t2_data_oe_cycles", 16'(oe_drv), 16'd5);
        check("t2_addr_data_stable", 16'(addr_bad), 16'd0);
        check("t2_done_count", 16'(done_cnt), 16'd1);
        check("t2_done_cycle", 16'(done_at), 16'd5);
        check("t2_rdata_kept", r_data2, 16'h0000);
        $display("txn2 store addr=1234 wdata=a5a5 we_low=%0d done_at=%0d", we_low, done_at);

        // Load with SysRdy low for 5 cycles in ACCESS
        addr = 16'h0100; mem_write = 1'b0; sys_data_in = 16'h1111; sys_rdy = 1'b0; mem_req = 1'b1;
        tick; mem_req = 1'b0;
        oe_low = 0; done_cnt = 0; done_at = 0; rdata_early = 16'h0;
        for (int i = 1; i <= 9; i++) begin
            if (!n_sys_oe) oe_low++;
            if (done) begin done_cnt++; done_at = i; end
            if (i == 7) rdata_early = r_data;
            if (i == 8) check("t3_rdata", r_data, 16'hCAFE);
            sys_rdy = (i >= 7);
            sys_data_in = (i >= 7) ? 16'hCAFE : 16'h1111;
            tick;
        end
        sys_rdy = 1'b1;
        check("t3_oe_low_cycles", 16'(oe_low), 16'd6);
        check("t3_done_count", 16'(done_cnt), 16'd1);
        check("t3_done_cycle", 16'(done_at), 16'd8);
        check("t3_rdata_before", rdata_early, 16'hBEEF);
        $display("txn3 load addr=0100 stretched rdata=%h", r_data);

        // Back-to-back: load 0001 then store 0002 with MemReq held
        addr = 16'h0001; mem_write = 1'b0; sys_data_in = 16'h7777; mem_req = 1'b1;
        tick;
        addr = 16'h0002; mem_write = 1'b1; wdata = 16'h5A5A;
        done_at = 0; done_at2 = 0; overlap = 0; we_low = 0; oe_low = 0;
        for (int i = 1; i <= 9; i++) begin
            if (!n_sys_oe && !n_sys_we) overlap++;
            if (!n_sys_oe) oe_low++;
            if (!n_sys_we) we_low++;
            if (done) begin
                if (done_at == 0) done_at = i;
                else done_at2 = i;
            end
            if (i == 2) check("t4_addr_ignored", sys_addr, 16'h0001);
            if (i == 3) check("t4_load_rdata", r_data, 16'h7777);
            if (i == 4) check("t4_idle_busy", busy, 1'b0);
            if (i == 5) begin
                check("t4_second_setup", sys_addr, 16'h0002);
                check("t4_second_oe_drv", sys_data_oe, 1'b1);
                mem_req = 1'b0;
            end
            tick;
        end
        check("t4_done_first", 16'(done_at), 16'd3);
        check("t4_done_second", 16'(done_at2), 16'd7);
        check("t4_overlap", 16'(overlap), 16'd0);
        check("t4_strobe_counts", 16'({oe_low[7:0], we_low[7:0]}), 16'h0101);
        check("t4_store_no_rdata", r_data, 16'h7777);
        $display("txn4 b2b load 0001 store 0002 done at %0d and %0d", done_at, done_at2);

        // Reset during a stalled store
        addr = 16'h0300; wdata = 16'h1357; mem_write = 1'b1; sys_rdy = 1'b0; mem_req = 1'b1;
        tick; mem_req = 1'b0;
        tick;
        check("t5_we_before", n_sys_we, 1'b0);
        #2 n_reset = 1'b0;
        #1;
        check("t5_async_strobes", {n_sys_ce, n_sys_oe, n_sys_we}, 3'b111);
        check("t5_busy", busy, 1'b0);
        check("t5_rdata", r_data, 16'h0000);
        check("t5_oe_drv", sys_data_oe, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (done) done_cnt++;
            tick;
        end
        n_reset = 1'b1; sys_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (done || busy) done_cnt++;
            tick;
        end
        check("t5_no_done", 16'(done_cnt), 16'd0);
        $display("txn5 store aborted by reset");

`ifdef MEM_TIMEOUT_EN
        // Load with SysRdy stuck low; watchdog expires after 8 ACCESS cycles
        addr = 16'h0500; mem_write = 1'b0; sys_rdy = 1'b0; mem_req = 1'b1;
        tick; mem_req = 1'b0;
        done_at = 0; err_at = 0; oe_low = 0;
        for (int i = 1; i <= 12; i++) begin
            if (!n_sys_oe) oe_low++;
            if (done && done_at == 0) done_at = i;
            if (bus_err && err_at == 0) err_at = i;
            if (i == 10) check("t6_rdata", r_data, 16'hFFFF);
            tick;
        end
        check("t6_done_cycle", 16'(done_at), 16'd10);
        check("t6_buserr_cycle", 16'(err_at), 16'd10);
        check("t6_oe_low_cycles", 16'(oe_low), 16'd8);
        sys_rdy = 1'b1; sys_data_in = 16'h2468; mem_req = 1'b1;
        tick; mem_req = 1'b0;
        tick; tick;
        check("t6_next_done", done, 1'b1);
        check("t6_next_buserr", bus_err, 1'b0);
        check("t6_next_rdata", r_data, 16'h2468);
        $display("txn6 timeout load then normal load rdata=%h", r_data);
`else
        err_at = 0;
        check("t6_buserr_tied", bus_err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
